// File: rtl/clk_div_scheduler.sv
// clk_div_scheduler: start/stop sequencing and period-aligned ratio switching for a clock divider.
// Outputs are registered from next-state values, so clk_out and tick line up with cnt.
module clk_div_scheduler #(
  parameter int CNT_W         = 8,
  parameter int DEFAULT_RATIO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             div_valid,
  input  logic [CNT_W-1:0] div_ratio,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_ratio,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, ratio_n, shadow, shadow_n;
  logic acc, take, end_p, run_n, clk_n, tick_n, err_n;
  assign div_ready = (state == IDLE) || (state == RUN);
  assign busy      = state != IDLE;
  always_comb begin
    acc      = div_valid && div_ready;
    take     = acc && (div_ratio >= CNT_W'(2));
    err_n    = acc && !take;
    end_p    = cnt == cur_ratio - CNT_W'(1);
    state_n  = state;
    cnt_n    = cnt;
    ratio_n  = cur_ratio;
    shadow_n = shadow;
    if (state == IDLE) begin
      ratio_n = take ? div_ratio : cur_ratio;
      state_n = enable ? RUN : IDLE;
      cnt_n   = '0;
    end else if (end_p) begin
      ratio_n  = take ? div_ratio : (shadow != '0 ? shadow : cur_ratio);
      shadow_n = '0;
      cnt_n    = '0;
      state_n  = enable ? RUN : IDLE;
    end else begin
      shadow_n = take ? div_ratio : shadow;
      cnt_n    = cnt + CNT_W'(1);
      state_n  = !enable ? STOP : (shadow_n != '0 ? PEND : RUN);
    end
    run_n  = state_n != IDLE;
    clk_n  = run_n && (cnt_n < (ratio_n >> 1));
    tick_n = run_n && (cnt_n == ratio_n - CNT_W'(1));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_ratio <= CNT_W'(DEFAULT_RATIO);
      shadow    <= '0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cur_ratio <= ratio_n;
      shadow    <= shadow_n;
      clk_out   <= clk_n;
      tick      <= tick_n;
      err       <= err_n;
    end
  end
endmodule

// File: doc/clk_div_scheduler.md
Name: clk_div_scheduler

Overview:
Run-time controller for the programmable clock divider. It sequences start and stop of the divided clock, and accepts new divide ratios over a valid/ready handshake. A new ratio takes effect only on a period boundary, so clk_out never shows a runt or truncated pulse. It sits between the configuration logic and any consumer of the divided clock or its tick strobe.

Parameters:
CNT_W, 8, width of the ratio and period counter; legal ratios are 2..2^CNT_W-1.
DEFAULT_RATIO, 4, ratio loaded at reset; must be >= 2.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-low: 0 resets, 1 runs.
enable  in  1  level; 1 requests the divided clock to run.
div_valid  in  1  new-ratio request is valid.
div_ratio  in  CNT_W  requested divide ratio N.
div_ready  out  1  controller can accept a ratio this cycle.
clk_out  out  1  divided clock, registered, glitch-free.
tick  out  1  one-cycle strobe in the last cycle of each period.
busy  out  1  high in RUN, PEND and STOP.
cur_ratio  out  CNT_W  ratio currently in use.
err  out  1  one-cycle pulse when an illegal ratio is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, cur_ratio=DEFAULT_RATIO, shadow=0, clk_out=0, tick=0, err=0, busy=0.
- States:
  - IDLE: counter stopped, clk_out=0.
  - RUN: dividing.
  - PEND: dividing, with a new ratio held in the shadow register.
  - STOP: enable has dropped; the current period is finishing.
- Handshake:
  - div_ready=1 in IDLE and RUN; 0 in PEND and STOP.
  - A request is accepted on the clk edge where div_valid & div_ready.
  - div_ratio < 2 is accepted (ready stays 1) but discarded: err pulses the next cycle, and state and cur_ratio are unchanged.
- Counter:
  - In RUN/PEND/STOP, cnt runs 0..cur_ratio-1 and then wraps to 0.
  - Period end is the cycle with cnt==cur_ratio-1.
- clk_out: registered; equals 1 for cnt < (cur_ratio>>1), 0 otherwise.
  - Odd N gives a high time of floor(N/2) cycles, e.g. N=5 gives 11000.
- tick: registered; high exactly in the period-end cycle.
- Transitions:
  - IDLE, enable=1: go to RUN next cycle with cnt=0, clk_out=1. A ratio accepted in IDLE loads cur_ratio directly and is used from the first period.
  - RUN, legal ratio accepted, not at period end: latch shadow and go to PEND.
  - RUN, legal ratio accepted in the period-end cycle: load cur_ratio at the wrap and stay in RUN.
  - PEND, at period end: cur_ratio<=shadow, cnt<=0, go to RUN. The new ratio governs the very next period.
  - RUN/PEND, enable=0: go to STOP. A pending shadow is kept.
  - STOP, enable=1 again before period end: return to RUN, or to PEND if a shadow is pending. There is no gap.
  - STOP, at period end: go to IDLE. Apply the shadow if one is pending. clk_out=0 from the next cycle.
- Same-cycle events:
  - enable falls in a period-end cycle: go directly to IDLE after the wrap.
  - A valid ratio and enable=1 arrive in the same cycle in IDLE: the ratio is used for the first period.
- cur_ratio changes only at a period boundary or in IDLE, never mid-period.
- rst asserted mid-period: all outputs take their reset values immediately (async). Restart after release needs enable=1 and begins at cnt=0.
- All outputs are flop-driven; no combinational path from inputs to outputs.

Test Plan:
- Reset, then enable=1, default N=4 -> clk_out repeats 1100 from the cycle after enable; tick high every 4th cycle (cnt=3); busy=1; cur_ratio=4.
- While running N=4, request 6 at cnt=1 -> div_ready drops, state PEND; the current period completes as 1100; the next periods are 111000 with tick every 6 cycles; cur_ratio becomes 6 at the wrap.
- In IDLE, request 5 then enable -> first period 11000, tick on the 5th cycle; repeat with the request in the same cycle as enable -> same result.
- Request 1, then 0 -> each is accepted with div_ready=1, err pulses for one cycle, cur_ratio unchanged, no break in the clk_out pattern.
- With N=4, drop enable at cnt=1 -> period finishes (cnt 2,3), tick at cnt=3, then IDLE with clk_out=0 and busy=0. Re-assert enable at cnt=2 in a second run -> no gap, pattern continues.
- Assert rst=0 mid-period at N=6 -> clk_out, tick and busy go to 0 asynchronously and cur_ratio returns to 4. After release with enable=1 -> 1100 pattern restarts from cnt=0.
